// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-write/two-read register file with byte enables, bypass and soft-clear sweep
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wea,
   input  logic                  web,
   input  logic [ADDR_W-1:0]     waddra,
   input  logic [ADDR_W-1:0]     waddrb,
   input  logic [DATA_W-1:0]     wdataa,
   input  logic [DATA_W-1:0]     wdatab,
   input  logic [DATA_W/8-1:0]   wbea,
   input  logic [DATA_W/8-1:0]   wbeb,
   input  logic [ADDR_W-1:0]     raddr1,
   input  logic [ADDR_W-1:0]     raddr2,
   output logic [DATA_W-1:0]     rdata1,
   output logic [DATA_W-1:0]     rdata2,
   input  logic                  clr,
   output logic                  busy,
   output logic                  wr_drop
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NB    = DATA_W/8;

   typedef enum logic {IDLE, SWEEP} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic                wr_drop_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                wen_a, wen_b;

   assign busy    = (state_q == SWEEP);
   assign wr_drop = wr_drop_q;

   // Writes that will actually land: none while sweeping, in reset, or into the hard-wired zero entry
   assign wen_a = rst && wea && !busy && !(ZERO_REG && (waddra == '0));
   assign wen_b = rst && web && !busy && !(ZERO_REG && (waddrb == '0));

   // Byte merge of both write ports over an old word; port B owns any byte it enables
   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic hit_a, input logic hit_b);
      logic [DATA_W-1:0] v;
      v = old;
      for (int i = 0; i < NB; i++) begin
         if (hit_b && wbeb[i])
            v[8*i +: 8] = wdatab[8*i +: 8];
         else if (hit_a && wbea[i])
            v[8*i +: 8] = wdataa[8*i +: 8];
      end
      return v;
   endfunction

   // One read port: stored word, optionally the post-write word, with entry 0 forced to zero
   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
      logic [DATA_W-1:0] v;
      v = mem_q[ra];
      if (BYPASS)
         v = merge(v, wen_a && (waddra == ra), wen_b && (waddrb == ra));
      if (ZERO_REG && (ra == '0))
         v = '0;
      return v;
   endfunction

   // Combinational read ports
   always_comb begin
      rdata1 = read_port(raddr1);
      rdata2 = read_port(raddr2);
   end

   // Soft-clear FSM next state: start on clr from IDLE, walk every entry once, ignore clr meanwhile
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (clr) begin
               state_d = SWEEP;
               ptr_d   = '0;
            end
         end
         SWEEP: begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (&ptr_q)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, sweep pointer and the registered drop indication
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         wr_drop_q <= busy && (wea || web);
      end
   end

   // Storage: sweep zeroes one entry per edge, otherwise apply the merged port writes
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (busy) begin
         mem_q[ptr_q] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= merge(mem_q[i], wen_a && (waddra == ADDR_W'(i)),
                              wen_b && (waddrb == ADDR_W'(i)));
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp, BYPASS=0 and BYPASS=1 instances side by side
module tb_regfile_mp;
   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        wea, web, clr;
   logic [4:0]  waddra, waddrb, raddr1, raddr2;
   logic [31:0] wdataa, wdatab;
   logic [3:0]  wbea, wbeb;
   logic [31:0] rd1_n, rd2_n, rd1_b, rd2_b;
   logic        busy_n, busy_b, drop_n, drop_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut (
      .clk(clk), .rst(rst), .wea(wea), .web(web), .waddra(waddra), .waddrb(waddrb),
      .wdataa(wdataa), .wdatab(wdatab), .wbea(wbea), .wbeb(wbeb),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n),
      .clr(clr), .busy(busy_n), .wr_drop(drop_n));

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_byp (
      .clk(clk), .rst(rst), .wea(wea), .web(web), .waddra(waddra), .waddrb(waddrb),
      .wdataa(wdataa), .wdatab(wdatab), .wbea(wbea), .wbeb(wbeb),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
      .clr(clr), .busy(busy_b), .wr_drop(drop_b));

   // ---------------- reference model ----------------
   logic [31:0] m_mem [DEPTH];
   int          m_sweep_left;
   int          m_sweep_idx;
   bit          m_drop;

   function automatic bit m_busy();
      return m_sweep_left > 0;
   endfunction

   // Word after this cycle's writes to addr: A applied first, then B on top
   function automatic logic [31:0] apply_writes(logic [31:0] old, logic [4:0] addr);
      logic [31:0] v;
      v = old;
      if (wea && waddra == addr)
         for (int b = 0; b < 4; b++) if (wbea[b]) v[8*b +: 8] = wdataa[8*b +: 8];
      if (web && waddrb == addr)
         for (int b = 0; b < 4; b++) if (wbeb[b]) v[8*b +: 8] = wdatab[8*b +: 8];
      return v;
   endfunction

   function automatic logic [31:0] m_read(logic [4:0] a, bit byp);
      if (a == 5'd0) return 32'd0;
      if (byp && !m_busy() && rst) return apply_writes(m_mem[a], a);
      return m_mem[a];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
      m_sweep_left = 0;
      m_sweep_idx  = 0;
      m_drop       = 1'b0;
   endtask

   task automatic model_edge();
      if (!rst) return;
      m_drop = m_busy() && (wea || web);
      if (m_busy()) begin
         m_mem[m_sweep_idx] = 32'd0;
         m_sweep_idx++;
         m_sweep_left--;
      end else begin
         for (int a = 1; a < DEPTH; a++) m_mem[a] = apply_writes(m_mem[a], 5'(a));
         if (clr) begin
            m_sweep_left = DEPTH;
            m_sweep_idx  = 0;
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       name;
   } exp_t;
   exp_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] get_act(int sel);
      case (sel)
         0: return rd1_n;
         1: return rd2_n;
         2: return {31'd0, busy_n};
         3: return {31'd0, drop_n};
         4: return rd1_b;
         5: return rd2_b;
         6: return {31'd0, busy_b};
         default: return {31'd0, drop_b};
      endcase
   endfunction

   task automatic push(input int sel, input logic [31:0] exp, input string name);
      exp_t e;
      e.sel  = sel;
      e.exp  = exp;
      e.name = name;
      q.push_back(e);
   endtask

   // Monitor: outputs are stable at the rising edge, midway between the active falling edges
   always @(posedge clk) begin : monitor
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk(e.name, get_act(e.sel), e.exp);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      wea = 1'b0; web = 1'b0; clr = 1'b0; wbea = 4'h0; wbeb = 4'h0;
   endtask

   task automatic tick();
      @(negedge clk);
      model_edge();
      #1;
      idle_inputs();
   endtask

   task automatic exp_rd(input logic [4:0] a1, input logic [4:0] a2, input string tag);
      raddr1 = a1;
      raddr2 = a2;
      push(0, m_read(a1, 1'b0), {tag, "_rd1"});
      push(1, m_read(a2, 1'b0), {tag, "_rd2"});
      push(4, m_read(a1, 1'b1), {tag, "_byp_rd1"});
      push(5, m_read(a2, 1'b1), {tag, "_byp_rd2"});
   endtask

   task automatic exp_st(input string tag);
      push(2, {31'd0, m_busy()}, {tag, "_busy"});
      push(3, {31'd0, m_drop},   {tag, "_wr_drop"});
      push(6, {31'd0, m_busy()}, {tag, "_byp_busy"});
      push(7, {31'd0, m_drop},   {tag, "_byp_wr_drop"});
   endtask

   task automatic write_a(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      wea = 1'b1; waddra = a; wdataa = d; wbea = be;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "bench did not finish");
   end

   initial begin : stim
      int busy_cnt;
      rst = 1'b0;
      idle_inputs();
      waddra = '0; waddrb = '0; wdataa = '0; wdatab = '0; raddr1 = '0; raddr2 = '0;
      m_reset();

      // reset state
      exp_st("reset");
      exp_rd(5'd0, 5'd5, "reset");
      tick();
      tick();
      rst = 1'b1;

      // every address written with i*5; entry 0 stays zero
      for (int i = 0; i < DEPTH; i++) begin
         write_a(5'(i), 32'(i * 5), 4'hF);
         exp_rd(5'(i), 5'((i + 1) % DEPTH), "fill");
         exp_st("fill");
         tick();
      end
      for (int i = 0; i < DEPTH; i++) begin
         exp_rd(5'(i), 5'(DEPTH - 1 - i), "readback");
         push(0, (i == 0) ? 32'd0 : 32'(i * 5), "readback_const");
         tick();
      end

      // partial byte write
      write_a(5'd7, 32'h11223344, 4'hF);
      tick();
      write_a(5'd7, 32'hAABBCCDD, 4'b0101);
      tick();
      exp_rd(5'd7, 5'd7, "byte_merge");
      push(0, 32'h11BB33DD, "byte_merge_const");
      tick();

      // same-address collision, B wins its enabled bytes
      write_a(5'd9, 32'hFFFFFFFF, 4'hF);
      web = 1'b1; waddrb = 5'd9; wdatab = 32'h00000000; wbeb = 4'b0011;
      tick();
      exp_rd(5'd9, 5'd9, "collision");
      push(0, 32'hFFFF0000, "collision_const");
      tick();

      // bypass vs no bypass on the same write
      write_a(5'd3, 32'hDEADBEEF, 4'hF);
      exp_rd(5'd3, 5'd0, "bypass");
      push(4, 32'hDEADBEEF, "bypass_const");
      push(0, 32'd15, "nobypass_const");
      tick();
      exp_rd(5'd3, 5'd3, "bypass_after");
      tick();

      // randomized traffic with occasional clears
      for (int n = 0; n < 250; n++) begin
         wea = 1'($urandom_range(0, 1)); web = 1'($urandom_range(0, 1));
         waddra = 5'($urandom_range(0, 31)); waddrb = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) waddrb = waddra;
         wdataa = $urandom; wdatab = $urandom;
         wbea = 4'($urandom_range(0, 15)); wbeb = 4'($urandom_range(0, 15));
         clr = ($urandom_range(0, 39) == 0);
         exp_rd(5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? waddra : 5'($urandom_range(0, 31)), "rand");
         exp_st("rand");
         tick();
      end
      for (int k = 0; k < 40 && m_busy(); k++) tick();

      // soft clear: exact busy length, dropped write, clr ignored mid-sweep
      for (int i = 1; i < DEPTH; i++) begin
         write_a(5'(i), $urandom | 32'h1, 4'hF);
         tick();
      end
      clr = 1'b1;
      tick();
      busy_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         busy_cnt += int'(busy_n);
         if (k == 3) write_a(5'd12, 32'hFFFFFFFF, 4'hF);
         if (k == 6) clr = 1'b1;
         exp_st("sweep");
         exp_rd(5'(k % DEPTH), 5'd12, "sweep");
         tick();
      end
      chk("sweep_busy_edges", 32'(busy_cnt), 32'd32);
      for (int i = 0; i < DEPTH; i++) begin
         exp_rd(5'(i), 5'(i), "after_clear");
         push(0, 32'd0, "after_clear_const");
         tick();
      end

      // reset in the middle of a sweep
      for (int i = 1; i < DEPTH; i++) begin
         write_a(5'(i), 32'(i) + 32'h100, 4'hF);
         tick();
      end
      clr = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) tick();
      rst = 1'b0;
      m_reset();
      exp_st("midreset");
      push(2, 32'd0, "midreset_busy_const");
      exp_rd(5'd1, 5'd20, "midreset");
      write_a(5'd4, 32'h5, 4'hF);
      clr = 1'b1;
      tick();
      exp_rd(5'd4, 5'd31, "held_reset");
      exp_st("held_reset");
      tick();
      rst = 1'b1;
      write_a(5'd4, 32'h5, 4'hF);
      exp_st("release");
      tick();
      exp_rd(5'd4, 5'd20, "post_reset");
      push(0, 32'h5, "post_reset_const");
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         exp_rd(5'(i), 5'((i * 7) % DEPTH), "final");
         exp_st("final");
         tick();
      end

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits; multiple of 8, range 8..64.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1: 1 = entry 0 reads 0 and ignores writes.
REQ-004 SHALL have parameter BYPASS, default 0: 1 = write data forwarded to read ports in the same cycle.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its falling edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports wea / web, input, 1 each: write enables for ports A and B.
REQ-008 SHALL have ports waddra / waddrb, input, ADDR_W each: write addresses.
REQ-009 SHALL have ports wdataa / wdatab, input, DATA_W each: write data.
REQ-010 SHALL have ports wbea / wbeb, input, DATA_W/8 each: byte enables; bit i covers data bits [8i+7:8i].
REQ-011 SHALL have ports raddr1 / raddr2, input, ADDR_W each: read addresses.
REQ-012 SHALL have ports rdata1 / rdata2, output, DATA_W each: read data, combinational.
REQ-013 SHALL have port clr, input, 1: soft-clear request, sampled on the falling edge.
REQ-014 SHALL have port busy, output, 1: high while the soft-clear sweep runs.
REQ-015 SHALL have port wr_drop, output, 1: one-cycle pulse when a write is discarded because busy is high.

Function
REQ-016 SHALL, on each falling edge with wea=1 and busy=0, write bytes of wdataa flagged in wbea to entry waddra; unflagged bytes keep their value.
REQ-017 SHALL handle port B identically to port A.
REQ-018 SHALL resolve port A and port B writing the same address on the same edge per byte: port B wins where its byte enable is set; otherwise port A applies where its byte enable is set.
REQ-019 SHALL, with ZERO_REG=1, discard writes to address 0 and return 0 on any read of address 0.
REQ-020 SHALL drive rdata1 / rdata2 as the stored word at raddr1 / raddr2, combinationally; both ports may read the same address.
REQ-021 SHALL, with BYPASS=1 and busy=0, return the post-write word (byte merge of REQ-016..018 over the stored value) when a read address matches an active write address; ZERO_REG still forces 0.
REQ-022 SHALL implement the soft-clear FSM with states IDLE and SWEEP and an ADDR_W-bit pointer ptr.
REQ-023 SHALL move IDLE -> SWEEP on a falling edge with clr=1, setting ptr=0; busy=1 from that edge on.
REQ-024 SHALL, in SWEEP, zero entry ptr and increment ptr on each falling edge; the edge that zeroes entry DEPTH-1 returns the FSM to IDLE and drops busy, so the sweep takes exactly DEPTH edges.
REQ-025 SHALL ignore clr while in SWEEP; no restart occurs.
REQ-026 SHALL, while busy=1, discard all writes and disable bypass; wr_drop is 1 for the cycle after any edge where wea or web was 1 and busy was 1, otherwise 0.
REQ-027 SHALL let reads during SWEEP return current contents: entries already swept read 0, entries not yet swept keep old data.

Reset
REQ-028 SHALL, on rst=0, asynchronously zero all entries, set the FSM to IDLE, set ptr=0, busy=0 and wr_drop=0, whatever state it was in, including mid-sweep.
REQ-029 SHALL ignore writes and clr while rst=0; normal operation resumes on the first falling edge after rst rises.

Verification (DATA_W=32, ADDR_W=5, ZERO_REG=1)
REQ-030 SHALL cover: write addresses i=0..31 with data i*5 and wbea=4'hF, then read them -> rdata(0)=0, rdata(i)=i*5 for i>=1.
REQ-031 SHALL cover: address 7 holds 32'h11223344; wea to 7 with data 32'hAABBCCDD and wbea=4'b0101 -> reads 32'h11BB33DD.
REQ-032 SHALL cover: wea and web both write address 9, data A=32'hFFFFFFFF with wbea=4'hF and data B=32'h00000000 with wbeb=4'b0011 -> reads 32'hFFFF0000.
REQ-033 SHALL cover: BYPASS=1 with wea to address 3 and data 32'hDEADBEEF while raddr1=3 before the edge -> rdata1=32'hDEADBEEF; same run with BYPASS=0 -> old value.
REQ-034 SHALL cover: clr pulse -> busy is high for exactly 32 edges; a write during busy gives a wr_drop pulse and the entry stays 0; all entries read 0 afterwards.
REQ-035 SHALL cover: rst=0 asserted at sweep edge 10, mid-clock -> busy=0 immediately, all entries read 0, and a write to address 4 of 32'h5 succeeds after release.
